// File: rtl/traffic_pkg.sv
// Shared light-head and phase encodings for the intersection traffic controllers.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10
  } phase_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req strictly after ptr,
// wrapping, with ptr itself considered last.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0] sh;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    sh    = '0;
    for (int k = 1; k <= N; k++) begin
      sh = req >> ((int'(ptr) + k) % N);
      if (!found && sh[0]) begin
        idx   = IDX_W'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Green-time scheduler for N_APPR approaches: round-robin with min/max green,
// yellow and all-red clearance, and emergency preempt.
import traffic_pkg::*;

module intersection_phase_arbiter #(
  parameter int N_APPR    = 4,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YEL_CYC   = 4,
  parameter int RED_CYC   = 2,
  parameter int TMR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_APPR-1:0]     req,
  input  logic                  preempt,
  input  logic [2:0]            preempt_id,
  output logic [3*N_APPR-1:0]   lights,
  output logic [2:0]            active_id,
  output logic [1:0]            phase,
  output logic                  phase_start
);

  localparam logic [TMR_W-1:0] T_RED = TMR_W'(RED_CYC - 1);
  localparam logic [TMR_W-1:0] T_YEL = TMR_W'(YEL_CYC - 1);
  localparam logic [TMR_W-1:0] T_MIN = TMR_W'(MIN_GREEN - 1);
  localparam logic [TMR_W-1:0] T_MAX = TMR_W'(MAX_GREEN - 1);

  phase_e              phase_q, phase_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [2:0]          act_q, act_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [2:0]          active_id_q, active_id_d;
  logic [3*N_APPR-1:0] lights_q, lights_d;
  logic                phase_start_q, phase_start_d;

  logic [N_APPR-1:0]   own_mask;
  logic                others, own_req, pre_vld;
  logic [2:0]          rr_idx;
  logic                rr_found;

  rr_pick #(.N(N_APPR), .IDX_W(3)) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_comb begin
    phase_d  = phase_q;
    act_d    = act_q;
    rr_ptr_d = rr_ptr_q;
    own_mask = N_APPR'(1) << act_q;
    others   = |(req & ~own_mask);
    own_req  = |(req & own_mask);
    // A preempt naming a nonexistent approach is treated as no preempt at all.
    pre_vld  = preempt && (int'(preempt_id) < N_APPR);

    unique case (phase_q)
      PH_ALL_RED: begin
        if (timer_q == T_RED) begin
          phase_d = PH_GREEN;
          if (pre_vld)       act_d = preempt_id;
          else if (rr_found) act_d = rr_idx;
          else               act_d = '0;
          rr_ptr_d = act_d;
        end
      end
      PH_GREEN: begin
        if (pre_vld) begin
          if (preempt_id != act_q) phase_d = PH_YELLOW;
        end else if (timer_q >= T_MIN && others && (!own_req || timer_q >= T_MAX)) begin
          phase_d = PH_YELLOW;
        end
      end
      PH_YELLOW: begin
        if (timer_q == T_YEL) phase_d = PH_ALL_RED;
      end
      default: phase_d = PH_ALL_RED;
    endcase

    if (phase_d != phase_q)  timer_d = '0;
    else if (&timer_q)       timer_d = timer_q;
    else                     timer_d = timer_q + 1'b1;

    active_id_d   = (phase_d == PH_ALL_RED) ? 3'd0 : act_d;
    phase_start_d = (phase_d != phase_q);

    lights_d = '0;
    for (int i = 0; i < N_APPR; i++) begin
      lights_d[3*i +: 3] = LT_RED;
      if (act_d == 3'(i)) begin
        if (phase_d == PH_GREEN)  lights_d[3*i +: 3] = LT_GRN;
        if (phase_d == PH_YELLOW) lights_d[3*i +: 3] = LT_YEL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q       <= PH_ALL_RED;
      timer_q       <= '0;
      act_q         <= '0;
      rr_ptr_q      <= 3'(N_APPR - 1);
      active_id_q   <= '0;
      lights_q      <= {N_APPR{LT_RED}};
      phase_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      timer_q       <= timer_d;
      act_q         <= act_d;
      rr_ptr_q      <= rr_ptr_d;
      active_id_q   <= active_id_d;
      lights_q      <= lights_d;
      phase_start_q <= phase_start_d;
    end
  end

  assign lights      = lights_q;
  assign active_id   = active_id_q;
  assign phase       = phase_q;
  assign phase_start = phase_start_q;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Directed bench for intersection_phase_arbiter with a per-cycle light-head monitor.
module tb_intersection_phase_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic        preempt;
  logic [2:0]  preempt_id;
  logic [11:0] lights;
  logic [2:0]  active_id;
  logic [1:0]  phase;
  logic        phase_start;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  logic [11:0] prev_lights;

  intersection_phase_arbiter #(
    .N_APPR(4), .MIN_GREEN(8), .MAX_GREEN(32), .YEL_CYC(4), .RED_CYC(2), .TMR_W(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .preempt     (preempt),
    .preempt_id  (preempt_id),
    .lights      (lights),
    .active_id   (active_id),
    .phase       (phase),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Length of the current phase, called from its first cycle.
  task automatic measure(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!phase_start && n < 300);
  endtask

  // Light-head safety monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      int nonred;
      bit bad;
      nonred = 0;
      bad    = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (lights[3*i +: 3] != 3'b100) nonred++;
        if (!(lights[3*i +: 3] inside {3'b100, 3'b010, 3'b001})) bad = 1'b1;
        if (prev_lights[3*i +: 3] == 3'b010 && lights[3*i +: 3] == 3'b001) bad = 1'b1;
        if (prev_lights[3*i +: 3] == 3'b100 && lights[3*i +: 3] == 3'b010) bad = 1'b1;
      end
      chk("mon_nonred_le1", 32'(nonred <= 1), 32'd1);
      chk("mon_transition", 32'(bad), 32'd0);
    end
    prev_lights = lights;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int exp_seq[4] = '{1, 2, 3, 0};
    rst_n = 1'b0; req = 4'b0000; preempt = 1'b0; preempt_id = 3'd0;

    // 1: reset, then rest on approach 0
    repeat (20) step();
    chk("rst_phase",  phase, 2'b00);
    chk("rst_lights", lights, 12'h924);
    chk("rst_active", active_id, 3'd0);
    chk("rst_pstart", phase_start, 1'b0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    step();
    chk("ar1_phase",  phase, 2'b00);
    chk("ar1_pstart", phase_start, 1'b0);
    step();
    chk("g0_phase",  phase, 2'b01);
    chk("g0_active", active_id, 3'd0);
    chk("g0_lights", lights, 12'h921);
    chk("g0_pstart", phase_start, 1'b1);
    repeat (100) step();
    chk("g0_hold_phase",  phase, 2'b01);
    chk("g0_hold_active", active_id, 3'd0);
    chk("g0_hold_pstart", phase_start, 1'b0);

    // 2: single request on approach 2
    req = 4'b0100;
    step();
    chk("y0_phase",  phase, 2'b10);
    chk("y0_lights", lights, 12'h922);
    chk("y0_pstart", phase_start, 1'b1);
    measure(n); chk("y0_len", n, 4);
    chk("ar_active", active_id, 3'd0);
    chk("ar_lights", lights, 12'h924);
    measure(n); chk("ar_len", n, 2);
    chk("g2_active", active_id, 3'd2);
    chk("g2_lights", lights, 12'h864);

    // min green: competing request appears at green start
    req = 4'b0001;
    measure(n); chk("g2_min_len", n, 8);
    chk("y2_lights", lights, 12'h8A4);
    measure(n); chk("y2_len", n, 4);
    measure(n); chk("ar2_len", n, 2);
    chk("g0b_active", active_id, 3'd0);

    // 3: all requesting -> round robin, each green hits max
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      measure(n); chk("rr_green_len", n, 32);
      measure(n); chk("rr_yel_len", n, 4);
      measure(n); chk("rr_red_len", n, 2);
      chk("rr_next_active", active_id, exp_seq[k]);
    end

    // 4: preempt to approach 3 while approach 1 green at timer 2
    measure(n); measure(n); measure(n);
    chk("g1_active", active_id, 3'd1);
    step(); step();
    preempt = 1'b1; preempt_id = 3'd3;
    step();
    chk("pre_y_phase",  phase, 2'b10);
    chk("pre_y_active", active_id, 3'd1);
    chk("pre_y_lights", lights, 12'h914);
    measure(n); chk("pre_y_len", n, 4);
    measure(n); chk("pre_ar_len", n, 2);
    chk("pre_g3_active", active_id, 3'd3);
    chk("pre_g3_lights", lights, 12'h324);
    repeat (40) step();
    chk("pre_hold_phase",  phase, 2'b01);
    chk("pre_hold_active", active_id, 3'd3);
    preempt = 1'b0;
    step();
    chk("post_pre_phase",  phase, 2'b10);
    chk("post_pre_lights", lights, 12'h524);
    measure(n); measure(n);
    chk("post_pre_next", active_id, 3'd0);

    // 5: reset during yellow
    req = 4'b0010;
    measure(n); chk("g0c_len", n, 8);
    chk("y0c_phase", phase, 2'b10);
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_phase",  phase, 2'b00);
    chk("mid_rst_lights", lights, 12'h924);
    chk("mid_rst_active", active_id, 3'd0);
    chk("mid_rst_pstart", phase_start, 1'b0);
    rst_n = 1'b1; req = 4'b1111;
    step();
    chk("mid_rst_ar2", phase, 2'b00);
    step();
    chk("mid_rst_gphase",  phase, 2'b01);
    chk("mid_rst_gactive", active_id, 3'd0);
    chk("mid_rst_gpstart", phase_start, 1'b1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
